// File: rtl/ctx_snapshot_port.sv
// Context access port: registered snapshots of a live state vector and
// toggle-signalled write-back detection producing single-cycle commit pulses.
module ctx_snapshot_port #(
    parameter int WIDTH      = 1024,
    parameter int N_WEN      = 1,
    parameter int FOUR_STATE = 0,
    localparam int PW        = (N_WEN > 1) ? $clog2(N_WEN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ctx_in,
    input  logic [WIDTH-1:0] ctx_xmask_in,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_xmask,
    input  logic [WIDTH-1:0] wr_payload,
    input  logic [N_WEN-1:0] wr_toggle,
    output logic             wr_valid,
    output logic [WIDTH-1:0] wr_data,
    output logic [PW-1:0]    wr_port,
    output logic [15:0]      wr_count
);

    typedef enum logic {
        ST_UNARMED = 1'b0,
        ST_ARMED   = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [N_WEN-1:0]   shadow_q, shadow_d;
    logic               rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [WIDTH-1:0]   rd_xmask_q, rd_xmask_d;
    logic               wr_valid_q, wr_valid_d;
    logic [WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [PW-1:0]      wr_port_q, wr_port_d;
    logic [15:0]        wr_count_q, wr_count_d;

    logic [N_WEN-1:0]   diff;
    logic               commit;
    logic               found;
    logic [PW-1:0]      low_idx;

    always_comb begin
        state_d    = ST_ARMED;
        shadow_d   = wr_toggle;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_xmask_d = rd_xmask_q;
        wr_valid_d = 1'b0;
        wr_data_d  = wr_data_q;
        wr_port_d  = wr_port_q;
        wr_count_d = wr_count_q;
        found      = 1'b0;
        low_idx    = '0;

        diff   = wr_toggle ^ shadow_q;
        commit = (state_q == ST_ARMED) && (diff != '0);

        // Priority pick of the lowest toggled index.
        for (int unsigned i = 0; i < N_WEN; i++) begin
            if (diff[i] && !found) begin
                found   = 1'b1;
                low_idx = PW'(i);
            end
        end

        if (commit) begin
            wr_valid_d = 1'b1;
            wr_data_d  = wr_payload;
            wr_port_d  = low_idx;
            if (wr_count_q != 16'hFFFF) begin
                wr_count_d = wr_count_q + 16'd1;
            end
        end

        // Write-before-read: a same-edge commit supplies the 2-state payload.
        if (rd_req) begin
            rd_valid_d = 1'b1;
            rd_data_d  = commit ? wr_payload : ctx_in;
            rd_xmask_d = (commit || FOUR_STATE == 0) ? '0 : ctx_xmask_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_UNARMED;
            shadow_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_xmask_q <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            wr_port_q  <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_xmask_q <= rd_xmask_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            wr_port_q  <= wr_port_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_xmask = rd_xmask_q;
    assign wr_valid = wr_valid_q;
    assign wr_data  = wr_data_q;
    assign wr_port  = wr_port_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_ctx_snapshot_port.sv
// Bench for ctx_snapshot_port: two configurations share stimulus and are
// compared every cycle against a behavioural model plus literal expectations.
module tb_ctx_snapshot_port;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req;
    logic [W-1:0]  ctx, xm, pay;
    logic [3:0]    tog;

    logic          a_rv, a_wv, b_rv, b_wv;
    logic [W-1:0]  a_rd, a_rx, a_wd, b_rd, b_rx, b_wd;
    logic [0:0]    a_port;
    logic [1:0]    b_port;
    logic [15:0]   a_cnt, b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ctx_snapshot_port #(.WIDTH(W), .N_WEN(1), .FOUR_STATE(1)) dut_a (
        .clk(clk), .reset(rst), .ctx_in(ctx), .ctx_xmask_in(xm), .rd_req(rd_req),
        .rd_valid(a_rv), .rd_data(a_rd), .rd_xmask(a_rx), .wr_payload(pay),
        .wr_toggle(tog[0]), .wr_valid(a_wv), .wr_data(a_wd), .wr_port(a_port),
        .wr_count(a_cnt)
    );

    ctx_snapshot_port #(.WIDTH(W), .N_WEN(4), .FOUR_STATE(0)) dut_b (
        .clk(clk), .reset(rst), .ctx_in(ctx), .ctx_xmask_in(xm), .rd_req(rd_req),
        .rd_valid(b_rv), .rd_data(b_rd), .rd_xmask(b_rx), .wr_payload(pay),
        .wr_toggle(tog), .wr_valid(b_wv), .wr_data(b_wd), .wr_port(b_port),
        .wr_count(b_cnt)
    );

    typedef struct {
        bit        armed;
        bit [3:0]  prev;
        bit        rv;
        bit [W-1:0] rd, rx;
        bit        wv;
        bit [W-1:0] wd;
        int        port;
        int        cnt;
    } model_t;

    model_t ma, mb;

    // Spec-level model: what each output must be after one clock edge.
    function automatic model_t step(model_t m, int n, bit fs);
        model_t r = m;
        bit [3:0] mask = 4'((1 << n) - 1);
        bit [3:0] t = tog & mask;
        bit [3:0] changed;
        bit did_commit = 0;
        if (rst) begin
            r = '{armed: 0, prev: 0, rv: 0, rd: 0, rx: 0, wv: 0, wd: 0, port: 0, cnt: 0};
            return r;
        end
        changed = m.armed ? (t ^ m.prev) : 4'b0;
        r.armed = 1;
        r.prev  = t;
        r.wv    = 0;
        if (changed != 0) begin
            did_commit = 1;
            r.wv  = 1;
            r.wd  = pay;
            r.cnt = (m.cnt < 65535) ? m.cnt + 1 : 65535;
            for (int i = n - 1; i >= 0; i--)
                if (changed[i]) r.port = i;
        end
        r.rv = rd_req;
        if (rd_req) begin
            r.rd = did_commit ? pay : ctx;
            r.rx = (did_commit || !fs) ? '0 : xm;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a_rd_valid", 32'(a_rv), 32'(ma.rv));
        check("a_rd_data",  32'(a_rd), 32'(ma.rd));
        check("a_rd_xmask", 32'(a_rx), 32'(ma.rx));
        check("a_wr_valid", 32'(a_wv), 32'(ma.wv));
        check("a_wr_data",  32'(a_wd), 32'(ma.wd));
        check("a_wr_port",  32'(a_port), 32'(ma.port));
        check("a_wr_count", 32'(a_cnt), 32'(ma.cnt));
        check("b_rd_valid", 32'(b_rv), 32'(mb.rv));
        check("b_rd_data",  32'(b_rd), 32'(mb.rd));
        check("b_rd_xmask", 32'(b_rx), 32'(mb.rx));
        check("b_wr_valid", 32'(b_wv), 32'(mb.wv));
        check("b_wr_data",  32'(b_wd), 32'(mb.wd));
        check("b_wr_port",  32'(b_port), 32'(mb.port));
        check("b_wr_count", 32'(b_cnt), 32'(mb.cnt));
    endtask

    // Inputs change only after this returns, so the model sees the sampled values.
    task automatic cycle();
        @(posedge clk);
        #1;
        ma = step(ma, 1, 1'b1);
        mb = step(mb, 4, 1'b0);
        compare_all();
    endtask

    initial begin
        ma = '{armed: 0, prev: 0, rv: 0, rd: 0, rx: 0, wv: 0, wd: 0, port: 0, cnt: 0};
        mb = ma;
        rst = 1; rd_req = 0; ctx = 0; xm = 0; pay = 0; tog = 4'b0001;
        cycle(); cycle();
        check("lit_reset_rd_valid", 32'(a_rv), 32'd0);
        check("lit_reset_wr_count", 32'(a_cnt), 32'd0);

        // Release with a non-zero toggle: arming edge must not commit.
        rst = 0;
        repeat (3) cycle();
        check("lit_arm_wr_count", 32'(a_cnt), 32'd0);
        check("lit_arm_wr_valid", 32'(b_wv), 32'd0);

        tog = 4'b0000; pay = 16'h00A5;
        cycle();
        check("lit_first_wr_valid", 32'(a_wv), 32'd1);
        check("lit_first_wr_data",  32'(a_wd), 32'h00A5);
        check("lit_first_wr_count", 32'(a_cnt), 32'd1);
        cycle();
        check("lit_pulse_ends", 32'(a_wv), 32'd0);

        rd_req = 1; ctx = 16'h003C; xm = 16'h000F;
        cycle();
        rd_req = 0;
        check("lit_rd_data",    32'(a_rd), 32'h003C);
        check("lit_rd_xmask_4", 32'(a_rx), 32'h000F);
        check("lit_rd_xmask_2", 32'(b_rx), 32'h0000);

        tog = 4'b1100; pay = 16'h0011;
        cycle();
        check("lit_multi_port",  32'(b_port), 32'd2);
        check("lit_multi_data",  32'(b_wd), 32'h0011);
        check("lit_multi_count", 32'(b_cnt), 32'd2);
        check("lit_multi_a_quiet", 32'(a_wv), 32'd0);
        cycle();

        rd_req = 1; ctx = 16'h0000; xm = 16'hFFFF; pay = 16'h007E; tog = tog ^ 4'b0001;
        cycle();
        rd_req = 0;
        check("lit_col_rd_valid", 32'(a_rv), 32'd1);
        check("lit_col_wr_valid", 32'(a_wv), 32'd1);
        check("lit_col_rd_data",  32'(a_rd), 32'h007E);
        check("lit_col_rd_xmask", 32'(a_rx), 32'h0000);

        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 39) == 0);
            rd_req = $urandom_range(0, 1) == 1;
            ctx    = 16'($urandom);
            xm     = 16'($urandom);
            pay    = 16'($urandom);
            if ($urandom_range(0, 2) != 0) tog = 4'($urandom);
            cycle();
        end

        // Reset one cycle after a read + toggle: pulses must be suppressed.
        rst = 0; rd_req = 0; cycle(); cycle();
        rd_req = 1; tog = tog ^ 4'b0001; ctx = 16'h1234;
        cycle();
        rst = 1; rd_req = 0;
        cycle();
        check("lit_rst_rd_valid", 32'(a_rv), 32'd0);
        check("lit_rst_wr_valid", 32'(a_wv), 32'd0);
        check("lit_rst_rd_data",  32'(a_rd), 32'd0);
        check("lit_rst_wr_data",  32'(b_wd), 32'd0);
        check("lit_rst_wr_count", 32'(b_cnt), 32'd0);
        rst = 0; tog = 4'b1011;
        cycle();
        check("lit_rearm_no_commit", 32'(b_wv), 32'd0);

        for (int i = 0; i < 70000; i++) begin
            tog = tog ^ 4'b0001;
            pay = 16'($urandom);
            cycle();
        end
        check("lit_sat_count",    32'(a_cnt), 32'hFFFF);
        check("lit_sat_wr_valid", 32'(a_wv), 32'd1);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctx_snapshot_port.md
Name: ctx_snapshot_port

Overview:
- Context access port for an emulated design partition.
- Takes one-cycle snapshots (reads) of a wide live state vector, in 2-state or 4-state form.
- Detects software write-back requests, which are signalled by toggling write-enable bits, and turns each into a single-cycle commit pulse carrying the payload.
- Sits between a state-holding module (register array, memory) and the host context-transfer channel.

Parameters:
- WIDTH, 1024, width of the context vector in bits (≥1).
- N_WEN, 1, number of independent write-enable toggle bits / write ports (1..16).
- FOUR_STATE, 0, 1 enables the X-mask path; 0 forces rd_xmask to zero.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ctx_in  input  WIDTH  live context value.
- ctx_xmask_in  input  WIDTH  per-bit unknown flag for ctx_in (1 = X); used only when FOUR_STATE=1.
- rd_req  input  1  snapshot request, sampled every cycle.
- rd_valid  output  1  one-cycle pulse; rd_data/rd_xmask are valid.
- rd_data  output  WIDTH  captured context value.
- rd_xmask  output  WIDTH  captured X mask.
- wr_payload  input  WIDTH  data to commit.
- wr_toggle  input  N_WEN  write-enable toggle bits; a change in any bit requests a commit.
- wr_valid  output  1  one-cycle commit pulse.
- wr_data  output  WIDTH  committed payload.
- wr_port  output  max(1,clog2(N_WEN))  index of the toggle bit that caused the commit.
- wr_count  output  16  saturating count of commits since reset.

Behaviour:
- All state updates on posedge clk. reset dominates all other inputs.
- Reset values:
  - rd_valid=0, rd_data=0, rd_xmask=0.
  - wr_valid=0, wr_data=0, wr_port=0, wr_count=0.
  - Toggle shadow=0, armed=0.
- Arming:
  - The first clock edge after reset deasserts loads shadow<=wr_toggle, sets armed=1, and commits nothing.
  - This prevents spurious commits from a non-zero toggle at reset release.
- Write detect (armed=1):
  - diff = wr_toggle ^ shadow.
  - If diff≠0: next cycle wr_valid=1, wr_data=wr_payload (sampled this edge), wr_port = lowest set index in diff, wr_count += 1 (saturating at 0xFFFF).
  - shadow<=wr_toggle every armed cycle.
  - Multiple toggled bits in the same cycle produce one commit, reporting the lowest index.
  - A bit toggling twice between samples is invisible (no commit).
  - wr_valid is high for exactly one cycle per detected change; otherwise 0. wr_data and wr_port hold their value between commits.
- Read:
  - rd_req=1 at an edge gives rd_valid=1 on the next cycle (latency 1).
  - rd_data = ctx_in sampled at that edge.
  - rd_xmask = ctx_xmask_in if FOUR_STATE=1, else all 0.
  - Back-to-back rd_req gives back-to-back snapshots; there is no busy state.
  - rd_data/rd_xmask hold between requests.
- Read/write collision:
  - If a commit is detected at the same edge as rd_req, rd_data returns wr_payload instead of ctx_in (write-before-read).
  - In that case rd_xmask is all 0, because written data is always 2-state.
- Reset mid-operation:
  - A pending rd_valid/wr_valid pulse is suppressed.
  - The block re-enters the unarmed state.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset release with wr_toggle=1 (WIDTH=8, N_WEN=1) -> no wr_valid in any cycle; wr_count=0; the next toggle to 0 with wr_payload=0xA5 gives wr_valid=1 one cycle later, wr_data=0xA5, wr_count=1.
- rd_req pulse with ctx_in=0x3C, ctx_xmask_in=0x0F, FOUR_STATE=1 -> next cycle rd_valid=1, rd_data=0x3C, rd_xmask=0x0F. Repeat with FOUR_STATE=0 -> rd_xmask=0x00.
- N_WEN=4, toggle bits 2 and 3 in the same cycle, payload 0x11 -> single wr_valid, wr_port=2, wr_data=0x11, wr_count +1.
- Collision: rd_req=1 and a toggle change in the same cycle with ctx_in=0x00, wr_payload=0x7E -> next cycle rd_valid=1, wr_valid=1, rd_data=0x7E, rd_xmask=0.
- 70000 alternating toggles -> wr_count saturates at 0xFFFF; wr_valid still pulses each time.
- Assert reset on the cycle after rd_req and a toggle change -> rd_valid=0, wr_valid=0, all outputs 0; the first post-reset edge arms without committing.
